tetron_rot_shaper: RTL

// - Parametrised successor of per-piece shapers: one block serves all 7 tetrominoes x 4 rotations.
// - Holds the current piece's rotation and drives 4 block offsets relative to the piece origin.
// - Runs a rotate request through a collision-check handshake with the board, optionally trying kicks.
// - Sits between game-control FSM (spawn/rotate) and board collision checker/renderer.

---
 rtl/tetron_pkg.sv | 29 ++
 rtl/tetron_shape_rom.sv | 60 ++++++
 rtl/tetron_rot_shaper.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tetron_pkg.sv
// Shared definitions for the tetromino rotation shaper: piece ids, rotation
// directions, FSM states and the wall-kick candidate table.
package tetron_pkg;

  localparam int OFS_W_DEF = 5;

  localparam logic [2:0] PC_I    = 3'd0;
  localparam logic [2:0] PC_O    = 3'd1;
  localparam logic [2:0] PC_T    = 3'd2;
  localparam logic [2:0] PC_S    = 3'd3;
  localparam logic [2:0] PC_Z    = 3'd4;
  localparam logic [2:0] PC_J    = 3'd5;
  localparam logic [2:0] PC_L    = 3'd6;
  localparam logic [2:0] PC_NONE = 3'd7;

  localparam logic ROT_CW  = 1'b0;
  localparam logic ROT_CCW = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_QUERY
  } state_t;

  // Kick candidates (v,h) in the order they are tried.
  localparam int KICK_V [4] = '{0,  0, 0, -1};
  localparam int KICK_H [4] = '{0, -1, 1,  0};

endpackage

// File: rtl/tetron_shape_rom.sv
// Combinational shape table: (piece, rotation) -> four (v,h) block offsets,
// blk1 in the LSBs. S uses a fixed table; other pieces rotate about blk1.
module tetron_shape_rom
  import tetron_pkg::*;
#(
  parameter int OFS_W = OFS_W_DEF
) (
  input  logic [2:0]         piece,
  input  logic [1:0]         rot,
  output logic [4*OFS_W-1:0] voffset,
  output logic [4*OFS_W-1:0] hoffset
);

  int  bv [4];
  int  bh [4];
  int  tmp;
  logic spin;

  always_comb begin
    bv   = '{0, 0, 0, 0};
    bh   = '{0, 0, 0, 0};
    tmp  = 0;
    spin = 1'b1;
    voffset = '0;
    hoffset = '0;
    case (piece)
      PC_I: begin bv = '{0, 0, 0, 0};  bh = '{0, -1, 1, 2};  end
      PC_O: begin bv = '{0, 0, 1, 1};  bh = '{0, 1, 0, 1};   spin = 1'b0; end
      PC_T: begin bv = '{0, 0, 0, -1}; bh = '{0, -1, 1, 0};  end
      PC_Z: begin bv = '{0, -1, 0, 1}; bh = '{0, 0, 1, 1};   end
      PC_J: begin bv = '{0, 0, 0, -1}; bh = '{0, -1, 1, -1}; end
      PC_L: begin bv = '{0, 0, 0, -1}; bh = '{0, -1, 1, 1};  end
      PC_S: begin
        spin = 1'b0;
        case (rot)
          2'd0:    begin bv = '{0, -1, 0, 1};  bh = '{0, 0, -1, -1}; end
          2'd1:    begin bv = '{0, -1, -1, 0}; bh = '{0, -1, 0, 1};  end
          2'd2:    begin bv = '{0, -1, 0, 1};  bh = '{1, 1, 0, 0};   end
          default: begin bv = '{1, 0, 0, 1};   bh = '{0, -1, 0, 1};  end
        endcase
      end
      default: spin = 1'b0;
    endcase
    // Clockwise quarter turn maps (v,h) to (h,-v); apply it rot times.
    for (int r = 0; r < 3; r++) begin
      if (spin && (r < int'(rot))) begin
        for (int b = 0; b < 4; b++) begin
          tmp   = bv[b];
          bv[b] = bh[b];
          bh[b] = -tmp;
        end
      end
    end
    for (int b = 0; b < 4; b++) begin
      voffset[b*OFS_W +: OFS_W] = OFS_W'(bv[b]);
      hoffset[b*OFS_W +: OFS_W] = OFS_W'(bh[b]);
    end
  end

endmodule

// File: rtl/tetron_rot_shaper.sv
// Tetromino rotation shaper: holds piece/rotation, drives block offsets and
// runs rotate requests through the board collision-check handshake.
// Build option: define TETRON_KICK_EN to try KICK_TRIES wall-kick candidates.
module tetron_rot_shaper
  import tetron_pkg::*;
#(
  parameter int OFS_W      = OFS_W_DEF,
  parameter int KICK_TRIES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic [2:0]           piece_id,
  input  logic                 spawn,
  input  logic                 rot_req,
  input  logic                 rot_dir,
  output logic                 rot_busy,
  output logic                 rot_done,
  output logic                 rot_ok,
  output logic                 chk_req,
  output logic [4*OFS_W-1:0]   chk_voffset,
  output logic [4*OFS_W-1:0]   chk_hoffset,
  input  logic                 chk_resp_valid,
  input  logic                 chk_collide,
  output logic [4*OFS_W-1:0]   blk_voffset,
  output logic [4*OFS_W-1:0]   blk_hoffset,
  output logic [1:0]           rotation
);

`ifdef TETRON_KICK_EN
  localparam bit KICK_EN = 1'b1;
`else
  localparam bit KICK_EN = 1'b0;
`endif
  localparam int TRIES = !KICK_EN ? 1 :
                         (KICK_TRIES > 4) ? 4 : (KICK_TRIES < 1) ? 1 : KICK_TRIES;
  localparam logic [1:0] LAST_KICK = 2'(TRIES - 1);
  localparam int VW = 4 * OFS_W;

  function automatic logic signed [VW-1:0] add_kick(input logic signed [VW-1:0] ofs,
                                                   input int delta);
    logic signed [VW-1:0] res;
    res = ofs;
    for (int b = 0; b < 4; b++)
      res[b*OFS_W +: OFS_W] = ofs[b*OFS_W +: OFS_W] + OFS_W'(delta);
    return res;
  endfunction

  state_t               state, state_nxt;
  logic [2:0]           piece_q;
  logic [1:0]           rotation_q, new_rot, kidx, kick_sel;
  logic                 done_q, ok_q;
  logic                 accept, load_cand, adv_kick, commit, reject;
  logic [2:0]           rom_piece;
  logic [1:0]           rom_rot;
  logic signed [VW-1:0] rom_v, rom_h, cand_v, cand_h, blk_v, blk_h;

  // Spawn addresses the new piece at rotation 0; otherwise the pending rotation.
  assign rom_piece = spawn ? piece_id : piece_q;
  assign rom_rot   = spawn ? 2'd0 : new_rot;
  assign kick_sel  = adv_kick ? kidx + 2'd1 : kidx;

  tetron_shape_rom #(.OFS_W(OFS_W)) u_rom (
    .piece   (rom_piece),
    .rot     (rom_rot),
    .voffset (rom_v),
    .hoffset (rom_h)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_cand = 1'b0;
    adv_kick  = 1'b0;
    commit    = 1'b0;
    reject    = 1'b0;
    if (!active || spawn) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (rot_req) begin
          accept    = 1'b1;
          state_nxt = ST_LOOKUP;
        end
        ST_LOOKUP: begin
          load_cand = 1'b1;
          state_nxt = ST_QUERY;
        end
        ST_QUERY: if (chk_resp_valid) begin
          if (!chk_collide) begin
            commit    = 1'b1;
            state_nxt = ST_IDLE;
          end else if (kidx == LAST_KICK) begin
            reject    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            adv_kick  = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      piece_q    <= PC_NONE;
      rotation_q <= 2'd0;
      new_rot    <= 2'd0;
      kidx       <= 2'd0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      blk_v      <= '0;
      blk_h      <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= commit | reject;
      ok_q   <= commit;
      if (spawn) begin
        piece_q    <= piece_id;
        rotation_q <= 2'd0;
        kidx       <= 2'd0;
        blk_v      <= rom_v;
        blk_h      <= rom_h;
      end else if (commit) begin
        rotation_q <= new_rot;
        blk_v      <= cand_v;
        blk_h      <= cand_h;
      end
      if (accept) begin
        case (rot_dir)
          ROT_CW:  new_rot <= rotation_q + 2'd1;
          ROT_CCW: new_rot <= rotation_q - 2'd1;
          default: new_rot <= rotation_q;
        endcase
        kidx <= 2'd0;
      end else if (adv_kick) begin
        kidx <= kick_sel;
      end
    end
  end

  // Candidate offsets are only observable while chk_req is high, so no reset.
  always_ff @(posedge clk) begin
    if (load_cand || adv_kick) begin
      cand_v <= add_kick(rom_v, KICK_V[kick_sel]);
      cand_h <= add_kick(rom_h, KICK_H[kick_sel]);
    end
  end

  assign rot_busy    = active && (state != ST_IDLE);
  assign rot_done    = active && done_q;
  assign rot_ok      = active && ok_q;
  assign chk_req     = active && (state == ST_QUERY);
  assign chk_voffset = chk_req ? cand_v : '0;
  assign chk_hoffset = chk_req ? cand_h : '0;
  assign blk_voffset = active ? blk_v : '0;
  assign blk_hoffset = active ? blk_h : '0;
  assign rotation    = active ? rotation_q : 2'd0;

endmodule
